// File: rtl/sprite_mix_pkg.sv
// sprite_mix_pkg: shared types and helpers for the sprite layer mixer
// and anything that needs to agree with its collision-map bit order.
package sprite_mix_pkg;

  localparam int RGB_W = 8;
  localparam logic [2:0] LAYER_NONE = 3'd7;

  typedef struct packed {
    logic [RGB_W-1:0] r;
    logic [RGB_W-1:0] g;
    logic [RGB_W-1:0] b;
  } rgb_t;

  // Bit position of pair (i,j), i<j, in row-major upper-triangle order
  function automatic int pair_index(
    input int i,
    input int j,
    input int n
  );
    return i * n - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/vsync_edge_detect.sv
// vsync_edge_detect: registered rising-edge detector whose history
// register resets high, so a vsync already high out of reset is ignored.
module vsync_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic v_i,
  output logic rise_o
);

  logic prev_q;
  logic rise_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prev_q <= 1'b1;
      rise_q <= 1'b0;
    end else begin
      prev_q <= v_i;
      rise_q <= v_i & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/sprite_layer_mixer.sv
// sprite_layer_mixer: two-stage priority mixer over sprite layers plus
// a per-frame pairwise collision map published on the vsync rise.
module sprite_layer_mixer
  import sprite_mix_pkg::*;
#(
  parameter int          N_LAYERS = 4,
  parameter logic [23:0] BG_RGB   = 24'h000000,
  localparam int         N_PAIRS  = N_LAYERS * (N_LAYERS - 1) / 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_de,
  input  logic                      i_v_sync,
  input  logic [N_LAYERS-1:0]       i_hit,
  input  logic [N_LAYERS*RGB_W-1:0] i_red,
  input  logic [N_LAYERS*RGB_W-1:0] i_green,
  input  logic [N_LAYERS*RGB_W-1:0] i_blue,
  output logic                      o_de,
  output logic [RGB_W-1:0]          o_red,
  output logic [RGB_W-1:0]          o_green,
  output logic [RGB_W-1:0]          o_blue,
  output logic [2:0]                o_layer_id,
  output logic [N_PAIRS-1:0]        o_collision,
  output logic                      o_frame_done,
  output logic [15:0]               o_frame_count
);

  localparam int PW = $clog2(N_PAIRS + 1);
  localparam rgb_t BG = rgb_t'(BG_RGB);

  logic                s1_de_q;
  logic [N_LAYERS-1:0] s1_hit_q;
  rgb_t                s1_rgb_q [N_LAYERS];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_de_q  <= 1'b0;
      s1_hit_q <= '0;
    end else begin
      s1_de_q  <= i_de;
      s1_hit_q <= i_hit;
    end
  end

  // colour needs no reset: it only reaches the output behind a hit flag
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < N_LAYERS; k++) begin
      s1_rgb_q[k] <= '{
        r: i_red[k*RGB_W +: RGB_W],
        g: i_green[k*RGB_W +: RGB_W],
        b: i_blue[k*RGB_W +: RGB_W]
      };
    end
  end

  rgb_t       win_d;
  logic [2:0] id_d;
  logic       found;

  always_comb begin
    win_d = BG;
    id_d  = LAYER_NONE;
    found = 1'b0;
    if (s1_de_q) begin
      for (int k = 0; k < N_LAYERS; k++) begin
        if (!found && s1_hit_q[k]) begin
          found = 1'b1;
          win_d = s1_rgb_q[k];
          id_d  = 3'(k);
        end
      end
    end
  end

  logic [N_PAIRS-1:0] pair_hit;

  always_comb begin
    pair_hit = '0;
    for (int i = 0; i < N_LAYERS; i++) begin
      for (int j = i + 1; j < N_LAYERS; j++) begin
        pair_hit[PW'(pair_index(i, j, N_LAYERS))] =
          s1_de_q & s1_hit_q[i] & s1_hit_q[j];
      end
    end
  end

  logic rise;

  vsync_edge_detect u_vs_edge (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .v_i    (i_v_sync),
    .rise_o (rise)
  );

  logic               de_q;
  rgb_t               pix_q;
  logic [2:0]         id_q;
  logic [N_PAIRS-1:0] acc_q, acc_d;
  logic [N_PAIRS-1:0] coll_q, coll_d;
  logic               done_q;
  logic [15:0]        frame_count_q, frame_count_d;

  // edge-cycle hits close the old frame and never leak into the new one
  always_comb begin
    acc_d         = acc_q | pair_hit;
    coll_d        = coll_q;
    frame_count_d = frame_count_q;
    if (rise) begin
      coll_d        = acc_q | pair_hit;
      acc_d         = '0;
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      de_q          <= 1'b0;
      pix_q         <= BG;
      id_q          <= LAYER_NONE;
      acc_q         <= '0;
      coll_q        <= '0;
      done_q        <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      de_q          <= s1_de_q;
      pix_q         <= win_d;
      id_q          <= id_d;
      acc_q         <= acc_d;
      coll_q        <= coll_d;
      done_q        <= rise;
      frame_count_q <= frame_count_d;
    end
  end

  assign o_de          = de_q;
  assign o_red         = pix_q.r;
  assign o_green       = pix_q.g;
  assign o_blue        = pix_q.b;
  assign o_layer_id    = id_q;
  assign o_collision   = coll_q;
  assign o_frame_done  = done_q;
  assign o_frame_count = frame_count_q;

endmodule

// File: tb/tb_sprite_layer_mixer.sv
// tb_sprite_layer_mixer: directed and randomized checks of the mixer
// against a behavioural pixel/frame model.
module tb_sprite_layer_mixer;
  import sprite_mix_pkg::*;

  localparam int N = 4;
  localparam int NP = 6;
  localparam logic [23:0] BG = 24'h102030;

  logic           clk = 1'b0;
  logic           rst_n, de, vs;
  logic [N-1:0]   hit;
  logic [8*N-1:0] red, green, blue;

  logic          o_de, o_done;
  logic [7:0]    o_r, o_g, o_b;
  logic [2:0]    o_id;
  logic [NP-1:0] o_coll;
  logic [15:0]   o_cnt;

  int total = 0;
  int bad = 0;
  int pulses;

  always #5 clk = ~clk;

  sprite_layer_mixer #(
    .N_LAYERS (N),
    .BG_RGB   (BG)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_de          (de),
    .i_v_sync      (vs),
    .i_hit         (hit),
    .i_red         (red),
    .i_green       (green),
    .i_blue        (blue),
    .o_de          (o_de),
    .o_red         (o_r),
    .o_green       (o_g),
    .o_blue        (o_b),
    .o_layer_id    (o_id),
    .o_collision   (o_coll),
    .o_frame_done  (o_done),
    .o_frame_count (o_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // lowest layer index with a hit wins; otherwise background
  function automatic logic [27:0] mix(
    input logic d, input logic [N-1:0] h,
    input logic [8*N-1:0] r, input logic [8*N-1:0] g,
    input logic [8*N-1:0] b
  );
    logic [27:0] res;
    res = {d, 3'd7, BG};
    if (d)
      for (int k = N - 1; k >= 0; k--)
        if (h[k])
          res = {1'b1, 3'(k), r[8*k +: 8], g[8*k +: 8], b[8*k +: 8]};
    return res;
  endfunction

  logic [27:0]    m_pix;
  logic           m_done, mvalid = 1'b0;
  logic [15:0]    m_cnt;
  logic [NP-1:0]  m_coll, acc, pend_map;
  logic           pend, prev_v;
  logic           h_de;
  logic [N-1:0]   h_hit;
  logic [8*N-1:0] h_r, h_g, h_b;
  logic           ovr_req = 1'b0, ovr_done = 1'b0;
  logic           no_chk = 1'b0;

  always @(posedge clk) begin
    if (ovr_req && !ovr_done) begin
      m_cnt = 16'hFFFE;
      ovr_done = 1'b1;
    end
    if (!rst_n) begin
      m_pix = {1'b0, 3'd7, BG};
      m_done = 1'b0;
      m_cnt = 16'd0;
      m_coll = '0;
      h_de = 1'b0;
      h_hit = '0;
      acc = '0;
      pend = 1'b0;
      prev_v = 1'b1;
      mvalid = 1'b1;
    end else begin
      m_pix = mix(h_de, h_hit, h_r, h_g, h_b);
      m_done = pend;
      if (pend) begin
        m_coll = pend_map;
        m_cnt = m_cnt + 16'd1;
      end
      pend = 1'b0;
      h_de = de;
      h_hit = hit;
      h_r = red;
      h_g = green;
      h_b = blue;
      if (de)
        for (int i = 0; i < N; i++)
          for (int j = i + 1; j < N; j++)
            if (hit[i] && hit[j])
              acc = acc | (NP'(1) << pair_index(i, j, N));
      if (vs && !prev_v) begin
        pend = 1'b1;
        pend_map = acc;
        acc = '0;
      end
      prev_v = vs;
    end
  end

  always @(negedge clk) begin
    if (mvalid && !no_chk) begin
      chk("pixel", {o_de, o_id, o_r, o_g, o_b}, m_pix);
      chk("frame", {o_done, o_cnt, o_coll}, {m_done, m_cnt, m_coll});
    end
  end

  initial begin
    rst_n = 1'b0; vs = 1'b1; de = 1'b0; hit = '0;
    red = '0; green = '0; blue = '0;
    cyc(); cyc();
    chk("rst_pix", {o_de, o_id, o_r, o_g, o_b}, {1'b0, 3'd7, BG});
    chk("rst_frm", {o_done, o_cnt, o_coll}, 64'd0);
    rst_n = 1'b1; cyc(); cyc();
    vs = 1'b0; cyc();

    de = 1'b1; hit = 4'b0100; red = '0; green = '0; blue = '0;
    red[23:16] = 8'h05; green[23:16] = 8'hC5; blue[23:16] = 8'hFF;
    cyc();
    hit = 4'b1010; red = 'x; green = 'x; blue = 'x;
    red[15:8] = 8'hFF; green[15:8] = 8'hFF; blue[15:8] = 8'hFF;
    cyc();
    chk("single", {o_de, o_id, o_r, o_g, o_b}, {1'b1, 3'd2, 24'h05C5FF});
    hit = '0; red = 'x; green = 'x; blue = 'x;
    cyc();
    chk("prio", {o_de, o_id, o_r, o_g, o_b}, {1'b1, 3'd1, 24'hFFFFFF});
    de = 1'b0; hit = 4'b1111;
    red = $urandom; green = $urandom; blue = $urandom;
    cyc();
    chk("nohit", {o_de, o_id, o_r, o_g, o_b}, {1'b1, 3'd7, BG});
    hit = '0;
    cyc();
    chk("de0", {o_de, o_id, o_r, o_g, o_b}, {1'b0, 3'd7, BG});
    vs = 1'b1; cyc(); cyc();
    chk("flush", {o_done, o_cnt, o_coll}, {1'b1, 16'd1, 6'b010000});
    vs = 1'b0; cyc();
    chk("done_off", {o_done, o_cnt, o_coll}, {1'b0, 16'd1, 6'b010000});

    de = 1'b1; hit = 4'b1001; cyc();
    de = 1'b0; hit = 4'b0110; cyc();
    hit = '0; cyc();
    vs = 1'b1; cyc(); cyc();
    chk("coll", {o_done, o_cnt, o_coll}, {1'b1, 16'd2, 6'b000100});
    vs = 1'b0; cyc(); cyc();
    vs = 1'b1; de = 1'b1; hit = 4'b1100; red = $urandom; cyc();
    de = 1'b0; hit = '0; cyc();
    chk("edgecol", {o_done, o_cnt, o_coll}, {1'b1, 16'd3, 6'b100000});
    vs = 1'b0; cyc(); cyc();
    vs = 1'b1; cyc(); cyc();
    chk("empty", {o_done, o_cnt, o_coll}, {1'b1, 16'd4, 6'b000000});

    vs = 1'b0; de = 1'b1; hit = 4'b0011; cyc();
    de = 1'b0; hit = '0; cyc();
    rst_n = 1'b0; vs = 1'b1; cyc();
    chk("midrst_pix", {o_de, o_id, o_r, o_g, o_b}, {1'b0, 3'd7, BG});
    chk("midrst_frm", {o_done, o_cnt, o_coll}, 64'd0);
    rst_n = 1'b1; cyc(); cyc(); cyc();
    chk("norise", {o_done, o_cnt, o_coll}, 64'd0);
    vs = 1'b0; cyc();
    vs = 1'b1; cyc(); cyc();
    chk("postrst", {o_done, o_cnt, o_coll}, {1'b1, 16'd1, 6'b000000});

    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 249) != 0);
      de = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) begin
        hit[k] = ($urandom_range(0, 2) == 0);
        if (hit[k])
          {red[8*k +: 8], green[8*k +: 8], blue[8*k +: 8]} = 24'($urandom);
        else
          {red[8*k +: 8], green[8*k +: 8], blue[8*k +: 8]} = 'x;
      end
      if ($urandom_range(0, 29) == 0) vs = ~vs;
      cyc();
    end

    rst_n = 1'b1; vs = 1'b0; de = 1'b0; hit = '0;
    cyc(); cyc(); cyc(); cyc();
    @(posedge clk); #1;
    no_chk = 1'b1;
    force dut.frame_count_q = 16'hFFFE;
    ovr_req = 1'b1;
    @(posedge clk); #1;
    release dut.frame_count_q;
    no_chk = 1'b0;
    cyc();
    vs = 1'b1; cyc(); cyc();
    chk("wrap_ff", 64'(o_cnt), 64'h0000_FFFF);
    vs = 1'b0; cyc();
    vs = 1'b1; cyc(); cyc();
    chk("wrap_0", 64'(o_cnt), 64'd0);
    vs = 1'b0; cyc(); cyc();
    vs = 1'b1; pulses = 0;
    for (int c = 0; c < 100; c++) begin
      cyc();
      if (o_done) pulses++;
    end
    chk("hold", 64'(pulses), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_layer_mixer.md
# sprite_layer_mixer

Pipelined priority mixer between the per-sprite compositors and the video output encoder. Each cycle it takes one pixel from every compositor (RGB plus opaque-hit flag), picks the highest-priority opaque layer or the background colour, and registers the result. It also builds a per-frame pairwise collision map from the hit flags and publishes it once per frame on the rising edge of vertical sync, for the game logic.

## Interface

Parameters:
- `N_LAYERS`, default 4: number of sprite compositors; range 2–8. Layer 0 has the highest priority.
- `BG_RGB`, default 24'h000000: background colour as {R,G,B}.
- `N_PAIRS`, derived as N_LAYERS*(N_LAYERS-1)/2: width of the collision map. Not overridable.

Ports:
- `i_clk` in 1: pixel clock.
- `i_rst_n` in 1: reset, synchronous, active-low.
- `i_de` in 1: pixel valid (active video).
- `i_v_sync` in 1: vertical sync, active-high, synchronous to `i_clk`.
- `i_hit` in N_LAYERS: per-layer opaque-pixel flag.
- `i_red`, `i_green`, `i_blue` in N_LAYERS×8 each: per-layer colour, packed with layer k at [8k+7:8k]. Don't-care (may be X) whenever `i_hit[k]`=0.
- `o_de` out 1: `i_de` delayed to match the pixel.
- `o_red`, `o_green`, `o_blue` out 8 each: mixed pixel.
- `o_layer_id` out 3: winning layer, or 7 for background.
- `o_collision` out N_PAIRS: collision map latched for the previous frame.
- `o_frame_done` out 1: one-cycle pulse when `o_collision` updates.
- `o_frame_count` out 16: number of completed frames, wraps.

## Operation

- **Stage 1:** register `i_de`, `i_hit`, and all RGB inputs.
- **Stage 2:** priority select on the stage-1 registers.
  - Winner is the lowest k with hit[k]=1. Output its RGB and `o_layer_id`=k.
  - If no hit, or if de=0, output `BG_RGB` and `o_layer_id`=7.
  - RGB of a non-hit layer must never reach the output, so X values must not propagate.
- **Pair index:** pairs are ordered (0,1),(0,2),…,(0,N−1),(1,2),…,(N−2,N−1), with bit index 0 first. For N=4 the order is (0,1)=0, (0,2)=1, (0,3)=2, (1,2)=3, (1,3)=4, (2,3)=5.
- **Collision accumulator:** an internal register `acc[N_PAIRS]`. A bit sets when stage-1 de=1 and both hit bits of that pair are 1. Bits are sticky within a frame.
- **Frame boundary:** vsync rising edge, detected as `i_v_sync`=1 while the registered previous value is 0.
  - `o_collision` ← acc | (this cycle's pair hits).
  - acc ← 0.
  - `o_frame_done` pulses for 1 cycle.
  - `o_frame_count` increments by 1, wrapping 16'hFFFF → 0.
- **Simultaneous collision and edge:** collisions in the edge cycle count toward the closing frame. They are not carried into the new frame.
- **Sustained vsync:** a held-high `i_v_sync` produces exactly one edge. No edge fires on the first cycle after reset if `i_v_sync` is already high, because the previous-vsync register resets to 1.

## Timing

- Pixel latency: exactly 2 cycles from the inputs to `o_red`/`o_green`/`o_blue`/`o_de`/`o_layer_id`. Throughput: 1 pixel per cycle, with no stalls.
- Collision latency: `o_collision` and `o_frame_done` are valid 2 cycles after the `i_v_sync` rising edge is sampled (1 cycle for edge detect, 1 for the output register). The stage-1 pixel in the edge cycle is included.
- Reset (`i_rst_n`=0 at a clock edge) sets:
  - both pipeline stages' de=0, hit=0;
  - `o_de`=0, `o_red`/`o_green`/`o_blue`=`BG_RGB`, `o_layer_id`=7;
  - `o_collision`=0, acc=0, `o_frame_done`=0, `o_frame_count`=0;
  - previous-vsync register = 1.
- Reset mid-frame discards the accumulated collisions. The first edge after reset publishes only post-reset collisions.

## Structure

- Package `sprite_mix_pkg` holds:
  - `RGB_W` = 8;
  - `LAYER_NONE` = 3'd7;
  - typedef `rgb_t` as a packed struct {r,g,b};
  - function `pair_index(i,j,n)`, shared by the RTL and the bench.
- One sub-module, `vsync_edge_detect`: registered rising-edge detector with reset value 1.
- The priority select is a for-loop priority encoder.

## Test plan

- **Single layer:** layer 2 hit with RGB 05/C5/FF, all others 0 → 2 cycles later output 05/C5/FF, `o_layer_id`=2.
- **Priority and X masking:** layers 1 and 3 hit; layer 1 is FF/FF/FF and the rest are X → output FF/FF/FF, id=1, no X on the outputs. No hit at all → `BG_RGB`, id=7.
- **Collision map:** during a frame, layers 0 and 3 overlap for 1 pixel and layers 1 and 2 overlap with de=0 → at the next vsync edge `o_collision`=6'b000100, `o_frame_done` pulses once, `o_frame_count`=1.
- **Edge-cycle collision:** a collision of (2,3) in the same cycle as the vsync edge → bit 5 is set in this frame's map. The following frame with no hits → map 0.
- **Reset mid-frame:** accumulate (0,1), assert `i_rst_n`=0 for 1 cycle with `i_v_sync` high → outputs hold the reset values, no edge fires, and the next real edge publishes 0.
- **Wrap:** force 65536 edges (or preload the count via a bench backdoor) → `o_frame_count` goes FFFF → 0000. With `i_v_sync` held high for 100 cycles → exactly one `o_frame_done`.
